lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit: the initiator side of the data-memory interface.
- Takes one load or store request from the core datapath and drives the word-only, synchronous-read data memory.
- Sub-word loads: extracts and sign- or zero-extends the addressed byte or halfword.
- Sub-word stores: performs a read-modify-write.
- Flags misaligned, out-of-range and illegal-funct3 requests without touching memory.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words in data memory. Word index req_addr[31:2] >= MEM_WORDS is an error.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request strobe; sampled only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bits used for SB/SH
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = request rejected
- rdata  out  32  formatted load result; holds until the next successful load
- mem_load  out  1  memory read enable
- mem_store  out  1  memory write enable
- mem_addr  out  32  word-aligned address: latched addr with [1:0] forced to 00
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid the cycle after mem_load, zero otherwise

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy, done, err, mem_load, mem_store = 0; rdata, mem_addr, mem_wdata, latched addr/funct3/wdata = 0.
- Reset mid-operation aborts immediately. A pending RMW write is never issued.
- States: IDLE, LD_REQ, LD_RSP, RMW_RD, RMW_MRG, WR, DONE.
- Moore outputs:
  - mem_load = 1 only in LD_REQ and RMW_RD.
  - mem_store = 1 only in WR.
  - done = 1 only in DONE.
- IDLE, req=1: latch addr, funct3, we, wdata, then classify:
  - illegal funct3 (load 011/110/111; store other than 000/001/010), halfword with addr[0]=1, word with addr[1:0]!=0, or word index >= MEM_WORDS -> DONE with err=1. No memory access.
  - load -> LD_REQ.
  - SW -> WR, with mem_wdata = req_wdata.
  - SB/SH -> RMW_RD.
- LD_REQ -> LD_RSP.
- LD_RSP: capture mem_rdata into rdata.
  - Select byte at addr[1:0] or halfword at addr[1].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Go to DONE with err=0.
- RMW_RD -> RMW_MRG.
- RMW_MRG: mem_wdata = mem_rdata with byte lane addr[1:0] (SB, wdata[7:0]) or halfword lane addr[1] (SH, wdata[15:0]) replaced. Go to WR.
- WR -> DONE with err=0.
- DONE -> IDLE.
- rdata changes only on successful loads. Stores and errors leave it unchanged.
- Latency, counting the req cycle as 0: error done at cycle 1; SW done at cycle 2; loads done at cycle 3; SB/SH done at cycle 4.
- req while busy (including DONE) is ignored, not queued.
- A new req is accepted in the IDLE cycle immediately after DONE.
- mem_addr and mem_wdata are held stable through each access.

Test Plan:
- Word store and load: memory zeroed; SW addr 0x10, wdata 0xDEADBEEF -> mem_store high exactly in cycle 1 with mem_addr 0x10 and mem_wdata 0xDEADBEEF; done=1, err=0 in cycle 2. Then LW 0x10 -> done in cycle 3, rdata 0xDEADBEEF.
- Sub-word loads, word 0x10 = 0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF; LB 0x10 -> 0xFFFFFFEF.
- Read-modify-write: SB 0x11, wdata 0x000000AA -> one mem_load, then mem_store with 0xDEADAAEF, done in cycle 4. Then SH 0x12, wdata 0x00001234 -> mem_wdata 0x1234AAEF. LW 0x10 then reads 0x1234AAEF.
- Errors: LH 0x11, SW 0x12, LW 0x1000 (word index 1024), and load funct3=011 -> each gives done=1, err=1 in cycle 1. mem_load and mem_store never asserted; rdata unchanged.
- Reset mid-RMW: SB 0x10 issued, rst_n pulled low during RMW_MRG -> outputs zero at once, mem_store never asserted, memory word unchanged, busy=0.
- Busy handling: hold req=1 continuously with LW 0x10 -> exactly one done per 4 cycles, no requests accepted while busy. A req in the DONE cycle is dropped.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit: initiator side of a word-only, synchronous-read data memory.
// Sub-word loads are extracted and extended from the returned word. Sub-word
// stores use a read-modify-write. Bad requests complete with err and never
// reach memory.
//
// Handshake: a request is taken only when req=1 in a cycle where busy=0. busy
// stays high from the cycle after acceptance through the done cycle. done is a
// one-cycle pulse, err is meaningful only while done=1, and a req presented
// while busy=1 is dropped, not queued.
module lsu_ctrl #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_load,
    output logic        mem_store,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, LD_REQ, LD_RSP, RMW_RD, RMW_MRG, WR, DONE
    } state_t;

    state_t      state;
    // Only the byte offset and the low halfword of store data are needed after
    // acceptance; the word address lives in mem_addr.
    logic [1:0]  addr_lo;
    logic [2:0]  funct3_q;
    logic [15:0] wdata_lo;

    logic        req_bad;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Classify an incoming request: illegal funct3, misalignment or out of range.
    always_comb begin
        req_bad = 1'b0;
        if (req_we) begin
            if (req_funct3 != 3'b000 && req_funct3 != 3'b001 && req_funct3 != 3'b010)
                req_bad = 1'b1;
        end else begin
            if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
                req_bad = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_bad = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            req_bad = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
            req_bad = 1'b1;
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        lane_byte = mem_rdata[{addr_lo, 3'b000} +: 8];
        lane_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_val = {24'd0, lane_byte};
            3'b101:  load_val = {16'd0, lane_half};
            default: load_val = mem_rdata;
        endcase
    end

    // Replace the store lane inside the word read back for a sub-word store.
    always_comb begin
        merge_val = mem_rdata;
        if (funct3_q[0]) begin
            if (addr_lo[1])
                merge_val[31:16] = wdata_lo;
            else
                merge_val[15:0] = wdata_lo;
        end else begin
            merge_val[{addr_lo, 3'b000} +: 8] = wdata_lo[7:0];
        end
    end

    // Control FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            mem_load  <= 1'b0;
            mem_store <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            addr_lo   <= 2'd0;
            funct3_q  <= 3'd0;
            wdata_lo  <= 16'd0;
        end else begin
            done      <= 1'b0;
            mem_load  <= 1'b0;
            mem_store <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_lo  <= req_addr[1:0];
                        funct3_q <= req_funct3;
                        wdata_lo <= req_wdata[15:0];
                        mem_addr <= {req_addr[31:2], 2'b00};
                        busy     <= 1'b1;
                        if (req_bad) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (!req_we) begin
                            state    <= LD_REQ;
                            mem_load <= 1'b1;
                        end else if (req_funct3 == 3'b010) begin
                            state     <= WR;
                            mem_store <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= RMW_RD;
                            mem_load <= 1'b1;
                        end
                    end
                end
                LD_REQ: state <= LD_RSP;
                LD_RSP: begin
                    rdata <= load_val;
                    state <= DONE;
                    done  <= 1'b1;
                    err   <= 1'b0;
                end
                RMW_RD: state <= RMW_MRG;
                RMW_MRG: begin
                    mem_wdata <= merge_val;
                    mem_store <= 1'b1;
                    state     <= WR;
                end
                WR: begin
                    state <= DONE;
                    done  <= 1'b1;
                    err   <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a byte-array reference model predicts each completion,
// a monitor pops the prediction whenever done pulses and compares it with the
// DUT and with the memory traffic seen since the previous completion.
module tb_lsu_ctrl;

    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] done_cyc;
        logic [1:0]  n_ld;
        logic [1:0]  n_st;
        logic [31:0] waddr;
        logic [31:0] wword;
    } exp_t;

    exp_t exp_q[$];

    // memory slave seen by the DUT
    logic [31:0] mem [0:MEM_WORDS-1] = '{default: '0};
    // reference model state
    logic [7:0]  ref_b [0:4*MEM_WORDS-1];
    logic [31:0] last_rdata;

    // monitor bookkeeping
    int          ld_cnt = 0;
    int          st_cnt = 0;
    int          st_cyc = 0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;

    lsu_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read memory: data the cycle after mem_load, zero otherwise
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= 32'd0;
        end else begin
            mem_rdata <= mem_load ? mem[mem_addr[11:2]] : 32'd0;
            if (mem_store)
                mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    // Reference model: access size from funct3, then plain byte arithmetic.
    task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int c);
        exp_t        e;
        int          size;
        logic        bad;
        logic [31:0] val;
        size = 0;
        if (we) begin
            if (f3 == 3'd0) size = 1;
            else if (f3 == 3'd1) size = 2;
            else if (f3 == 3'd2) size = 4;
        end else begin
            if (f3 == 3'd0 || f3 == 3'd4) size = 1;
            else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
            else if (f3 == 3'd2) size = 4;
        end
        bad = (size == 0);
        if (!bad && (addr % size) != 0) bad = 1'b1;
        if ((addr >> 2) >= MEM_WORDS) bad = 1'b1;
        e = '0;
        e.err = bad;
        if (bad) begin
            e.done_cyc = c + 1;
        end else if (!we) begin
            val = 32'd0;
            for (int i = 0; i < size; i++)
                val = val | (32'(ref_b[addr + i]) << (8 * i));
            if (!f3[2] && size < 4 && val[8*size-1])
                val = val | (32'hFFFF_FFFF << (8 * size));
            last_rdata = val;
            e.n_ld     = 2'd1;
            e.done_cyc = c + 3;
        end else begin
            for (int i = 0; i < size; i++)
                ref_b[addr + i] = 8'(wdata >> (8 * i));
            e.n_ld     = (size == 4) ? 2'd0 : 2'd1;
            e.n_st     = 2'd1;
            e.waddr    = {addr[31:2], 2'b00};
            e.wword    = ref_word(int'(addr[31:2]));
            e.done_cyc = c + ((size == 4) ? 2 : 4);
        end
        e.rdata = last_rdata;
        exp_q.push_back(e);
    endtask

    // monitor: count memory strobes, compare against the prediction on done
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ld_cnt = 0;
            st_cnt = 0;
        end else begin
            if (mem_load) ld_cnt++;
            if (mem_store) begin
                st_cnt++;
                st_addr = mem_addr;
                st_data = mem_wdata;
                st_cyc  = cyc;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("err", {31'd0, err}, {31'd0, e.err});
                    check("rdata", rdata, e.rdata);
                    check("done_cycle", cyc, e.done_cyc);
                    check("mem_load_count", ld_cnt, {30'd0, e.n_ld});
                    check("mem_store_count", st_cnt, {30'd0, e.n_st});
                    if (e.n_st != 2'd0) begin
                        check("store_addr", st_addr, e.waddr);
                        check("store_data", st_data, e.wword);
                        check("store_cycle", st_cyc, e.done_cyc - 1);
                    end
                end
                ld_cnt = 0;
                st_cnt = 0;
            end
        end
    end

    // driver: one request, then wait (bounded) for its done
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int k;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        req        = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        model_push(we, f3, addr, wdata, cyc);
        @(negedge clk);
        req = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done)
            check("done_timeout", 32'd0, 32'd1);
    endtask

    // hold req high with LW 0x10; one acceptance every 4 cycles
    task automatic hold_lw(input int n);
        int c;
        int k;
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < n; i++)
            model_push(1'b0, 3'b010, 32'h10, 32'd0, c + 4 * i);
        req        = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'd0;
        repeat (4 * n - 3) @(negedge clk);
        req = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 4 * n + 10) begin
            @(negedge clk);
            k++;
        end
        check("hold_queue_drained", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // main sequence
    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        req        = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        last_rdata = 32'd0;
        for (int i = 0; i < 4 * MEM_WORDS; i++) ref_b[i] = 8'd0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_load", {31'd0, mem_load}, 32'd0);
        check("rst_mem_store", {31'd0, mem_store}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // word store and load
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h10, 32'd0);
        check("lw_deadbeef", rdata, 32'hDEADBEEF);
        // sub-word loads
        issue(1'b0, 3'b000, 32'h13, 32'd0);
        check("lb_13", rdata, 32'hFFFFFFDE);
        issue(1'b0, 3'b100, 32'h13, 32'd0);
        issue(1'b0, 3'b001, 32'h12, 32'd0);
        check("lh_12", rdata, 32'hFFFFDEAD);
        issue(1'b0, 3'b101, 32'h10, 32'd0);
        check("lhu_10", rdata, 32'h0000BEEF);
        issue(1'b0, 3'b000, 32'h10, 32'd0);
        // read-modify-write
        issue(1'b1, 3'b000, 32'h11, 32'h000000AA);
        check("sb_word", mem[4], 32'hDEADAAEF);
        issue(1'b1, 3'b001, 32'h12, 32'h00001234);
        issue(1'b0, 3'b010, 32'h10, 32'd0);
        check("lw_after_rmw", rdata, 32'h1234AAEF);
        // errors
        issue(1'b0, 3'b001, 32'h11, 32'd0);
        issue(1'b1, 3'b010, 32'h12, 32'h11111111);
        issue(1'b0, 3'b010, 32'h1000, 32'd0);
        issue(1'b0, 3'b011, 32'h10, 32'd0);
        check("rdata_kept_after_errors", rdata, 32'h1234AAEF);

        // reset in the middle of a read-modify-write
        @(negedge clk);
        req        = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h55;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_mem_store", {31'd0, mem_store}, 32'd0);
        check("abort_mem_load", {31'd0, mem_load}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        last_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_store", st_cnt, 32'd0);
        check("abort_word_kept", mem[4], 32'h1234AAEF);
        check("abort_idle", {31'd0, busy}, 32'd0);

        // continuous req while busy
        hold_lw(4);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 11) == 0)
                a = 32'h1000 + 32'($urandom_range(0, 255));
            else if ($urandom_range(0, 19) == 0)
                a = $urandom;
            else
                a = 32'($urandom_range(0, 63));
            issue(we, f3, a, $urandom);
        end

        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++)
            check("final_mem", mem[i], ref_word(i));
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
